// File: rtl/button_pkg.sv
// Shared definitions for the two-button conditioner: per-channel FSM state
// encoding, default timing constants and a counter-width helper.
package button_pkg;

    // One FSM per button channel.
    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } btn_state_t;

    // Defaults assume a 9 MHz clock.
    localparam int DEF_DEBOUNCE_CYCLES   = 90000;    // 10 ms
    localparam int DEF_LONG_PRESS_CYCLES = 4500000;  // 500 ms
    localparam int DEF_REPEAT_CYCLES     = 900000;   // 100 ms
    localparam bit DEF_ACTIVE_LOW        = 1'b1;

    // Width of a counter that must be able to hold max_count.
    function automatic int cnt_width(input int max_count);
        return $clog2(max_count) + 1;
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Per-channel event bundle: debounced level, one-cycle press/release/repeat
// pulses and the channel FSM state for observation.
//
// Handshake: there is no backpressure. The master (button_channel) asserts
// press, rel and rpt for exactly one clock each; a slave must sample them on
// every rising clock edge. btn is a level and state is informational only.
interface button_conditioner_if;
    import button_pkg::*;

    logic       btn;
    logic       press;
    logic       rel;
    logic       rpt;
    btn_state_t state;

    modport master (output btn, press, rel, rpt, state);
    modport slave  (input  btn, press, rel, rpt, state);
endinterface

// File: rtl/button_channel.sv
// One button: 2-flop synchronizer, polarity normalisation, debounce FSM with
// press/release pulses and long-press auto-repeat.
module button_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
    parameter int REPEAT_CYCLES     = DEF_REPEAT_CYCLES,
    parameter bit ACTIVE_LOW        = DEF_ACTIVE_LOW
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    button_conditioner_if.master evt
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end
    if (LONG_PRESS_CYCLES < 1) begin : g_bad_long_press
        $error("LONG_PRESS_CYCLES must be at least 1");
    end
    if (REPEAT_CYCLES < 1) begin : g_bad_repeat
        $error("REPEAT_CYCLES must be at least 1");
    end

    localparam int DB_W     = cnt_width(DEBOUNCE_CYCLES);
    localparam int HOLD_MAX = (LONG_PRESS_CYCLES > REPEAT_CYCLES) ? LONG_PRESS_CYCLES : REPEAT_CYCLES;
    localparam int HOLD_W   = cnt_width(HOLD_MAX);

    // The sample that leaves IDLE/HELD is the first of the debounce run, so a
    // wait state only needs DEBOUNCE_CYCLES-1 more samples (counter 0..N-2).
    localparam bit             SINGLE    = (DEBOUNCE_CYCLES == 1);
    localparam int             DB_LAST_I = (DEBOUNCE_CYCLES >= 2) ? DEBOUNCE_CYCLES - 2 : 0;
    localparam logic [DB_W-1:0] DB_LAST  = DB_LAST_I[DB_W-1:0];

    // Hold counter restarts from 0 at every repeat pulse, so it never wraps.
    localparam int               LONG_M1_I = LONG_PRESS_CYCLES - 1;
    localparam int               REP_M1_I  = REPEAT_CYCLES - 1;
    localparam logic [HOLD_W-1:0] LONG_M1  = LONG_M1_I[HOLD_W-1:0];
    localparam logic [HOLD_W-1:0] REP_M1   = REP_M1_I[HOLD_W-1:0];

    // Synchronizer resets to the level the pin shows when not pressed.
    localparam logic PIN_IDLE = ACTIVE_LOW ? 1'b1 : 1'b0;

    logic [1:0]        sync;
    logic              active;
    btn_state_t        state;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_limit;
    logic              rpt_phase;
    logic              btn_q;
    logic              press_q;
    logic              rel_q;
    logic              rpt_q;

    // Two-flop synchronizer for the asynchronous pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= {2{PIN_IDLE}};
        end else begin
            sync <= {sync[0], pin};
        end
    end

    assign active     = ACTIVE_LOW ? ~sync[1] : sync[1];
    assign hold_limit = rpt_phase ? REP_M1 : LONG_M1;

    // Debounce / hold FSM; all outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            db_cnt    <= '0;
            hold_cnt  <= '0;
            rpt_phase <= 1'b0;
            btn_q     <= 1'b0;
            press_q   <= 1'b0;
            rel_q     <= 1'b0;
            rpt_q     <= 1'b0;
        end else begin
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            rpt_q   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (active) begin
                        db_cnt <= '0;
                        if (SINGLE) begin
                            state     <= ST_HELD;
                            btn_q     <= 1'b1;
                            press_q   <= 1'b1;
                            hold_cnt  <= '0;
                            rpt_phase <= 1'b0;
                        end else begin
                            state <= ST_PRESS_WAIT;
                        end
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!active) begin
                        state <= ST_IDLE;
                    end else if (db_cnt == DB_LAST) begin
                        state     <= ST_HELD;
                        btn_q     <= 1'b1;
                        press_q   <= 1'b1;
                        hold_cnt  <= '0;
                        rpt_phase <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!active) begin
                        db_cnt <= '0;
                        if (SINGLE) begin
                            state <= ST_IDLE;
                            btn_q <= 1'b0;
                            rel_q <= 1'b1;
                        end else begin
                            state <= ST_RELEASE_WAIT;
                        end
                    end else if (hold_cnt == hold_limit) begin
                        rpt_q     <= 1'b1;
                        hold_cnt  <= '0;
                        rpt_phase <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_RELEASE_WAIT: begin
                    // hold_cnt is left untouched so a bounce resumes the hold.
                    if (active) begin
                        state <= ST_HELD;
                    end else if (db_cnt == DB_LAST) begin
                        state <= ST_IDLE;
                        btn_q <= 1'b0;
                        rel_q <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign evt.btn   = btn_q;
    assign evt.press = press_q;
    assign evt.rel   = rel_q;
    assign evt.rpt   = rpt_q;
    assign evt.state = state;

endmodule

// File: rtl/button_conditioner.sv
// Two independent button channels (A and B) sharing one clock and reset.
module button_conditioner
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
    parameter int REPEAT_CYCLES     = DEF_REPEAT_CYCLES,
    parameter bit ACTIVE_LOW        = DEF_ACTIVE_LOW
) (
    input  logic       i_clk,
    input  logic       i_res_n,
    input  logic       i_btn_a,
    input  logic       i_btn_b,
    output logic       o_btn_a,
    output logic       o_btn_b,
    output logic       o_press_a,
    output logic       o_press_b,
    output logic       o_release_a,
    output logic       o_release_b,
    output logic       o_repeat_a,
    output logic       o_repeat_b,
    output btn_state_t o_dbg_state_a,
    output btn_state_t o_dbg_state_b
);

    button_conditioner_if ch_a_if ();
    button_conditioner_if ch_b_if ();

    button_channel #(
        .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
        .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES),
        .REPEAT_CYCLES     (REPEAT_CYCLES),
        .ACTIVE_LOW        (ACTIVE_LOW)
    ) u_chan_a (
        .clk   (i_clk),
        .rst_n (i_res_n),
        .pin   (i_btn_a),
        .evt   (ch_a_if.master)
    );

    button_channel #(
        .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
        .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES),
        .REPEAT_CYCLES     (REPEAT_CYCLES),
        .ACTIVE_LOW        (ACTIVE_LOW)
    ) u_chan_b (
        .clk   (i_clk),
        .rst_n (i_res_n),
        .pin   (i_btn_b),
        .evt   (ch_b_if.master)
    );

    assign o_btn_a       = ch_a_if.btn;
    assign o_press_a     = ch_a_if.press;
    assign o_release_a   = ch_a_if.rel;
    assign o_repeat_a    = ch_a_if.rpt;
    assign o_dbg_state_a = ch_a_if.state;

    assign o_btn_b       = ch_b_if.btn;
    assign o_press_b     = ch_b_if.press;
    assign o_release_b   = ch_b_if.rel;
    assign o_repeat_b    = ch_b_if.rpt;
    assign o_dbg_state_b = ch_b_if.state;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with short timing parameters. Expected pulse
// events (cycle number + pulse vector) are queued by the stimulus; a monitor
// on the falling edge pops and compares whenever any pulse output is high.
module tb_button_conditioner;
    import button_pkg::*;

    localparam int DB   = 4;
    localparam int LONG = 10;
    localparam int REP  = 3;
    localparam int LAT  = DB + 2;

    // Pulse vector layout: {rep_b, rel_b, prs_b, rep_a, rel_a, prs_a}
    localparam logic [5:0] PRS_A = 6'b000001;
    localparam logic [5:0] REL_A = 6'b000010;
    localparam logic [5:0] REP_A = 6'b000100;
    localparam logic [5:0] PRS_B = 6'b001000;
    localparam logic [5:0] REL_B = 6'b010000;

    localparam int W = 38;  // {cycle[31:0], vec[5:0]}

    logic       clk;
    logic       res_n;
    logic       btn_a;
    logic       btn_b;
    logic       o_btn_a, o_btn_b;
    logic       o_press_a, o_press_b;
    logic       o_release_a, o_release_b;
    logic       o_repeat_a, o_repeat_b;
    btn_state_t st_a, st_b;

    int         cyc;
    int         pass_cnt;
    int         total_cnt;
    logic [W-1:0] exp_q[$];

    button_conditioner_if mon_a ();
    button_conditioner_if mon_b ();

    button_conditioner #(
        .DEBOUNCE_CYCLES   (DB),
        .LONG_PRESS_CYCLES (LONG),
        .REPEAT_CYCLES     (REP),
        .ACTIVE_LOW        (1'b1)
    ) dut (
        .i_clk         (clk),
        .i_res_n       (res_n),
        .i_btn_a       (btn_a),
        .i_btn_b       (btn_b),
        .o_btn_a       (o_btn_a),
        .o_btn_b       (o_btn_b),
        .o_press_a     (o_press_a),
        .o_press_b     (o_press_b),
        .o_release_a   (o_release_a),
        .o_release_b   (o_release_b),
        .o_repeat_a    (o_repeat_a),
        .o_repeat_b    (o_repeat_b),
        .o_dbg_state_a (st_a),
        .o_dbg_state_b (st_b)
    );

    assign mon_a.btn   = o_btn_a;
    assign mon_a.press = o_press_a;
    assign mon_a.rel   = o_release_a;
    assign mon_a.rpt   = o_repeat_a;
    assign mon_a.state = st_a;
    assign mon_b.btn   = o_btn_b;
    assign mon_b.press = o_press_b;
    assign mon_b.rel   = o_release_b;
    assign mon_b.rpt   = o_repeat_b;
    assign mon_b.state = st_b;

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // Driver helpers
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int at_cyc, input logic [5:0] vec);
        exp_q.push_back({at_cyc[31:0], vec});
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [5:0]   vec;
        logic [W-1:0] e;
        vec = {mon_b.rpt, mon_b.rel, mon_b.press, mon_a.rpt, mon_a.rel, mon_a.press};
        if (vec != 6'b0) begin
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_pulse: got vec %b at cycle %0d, expected no pulse", vec, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e[37:6] == cyc[31:0] && e[5:0] == vec) pass_cnt++;
                else $display("FAIL pulse_event: got vec %b at cycle %0d, expected vec %b at cycle %0d",
                              vec, cyc, e[5:0], e[37:6]);
            end
        end
    end

    // Stimulus
    initial begin
        int t0, t1, t2, t3, t4, t5, t6;
        int wait_cyc;
        pass_cnt  = 0;
        total_cnt = 0;
        res_n = 1'b0;
        btn_a = 1'b1;
        btn_b = 1'b1;

        // Reset state
        tick(3);
        check("reset_outputs", {24'b0, o_btn_a, o_btn_b, o_press_a, o_press_b,
                                o_release_a, o_release_b, o_repeat_a, o_repeat_b}, 32'd0);
        check("reset_state_a", {30'b0, st_a}, {30'b0, ST_IDLE});
        check("reset_state_b", {30'b0, st_b}, {30'b0, ST_IDLE});
        res_n = 1'b1;
        tick(3);

        // Clean press with auto-repeat, then bouncy release
        t0 = cyc;
        btn_a = 1'b0;
        push(t0 + LAT, PRS_A);
        for (int k = LONG; k <= 28; k += REP) push(t0 + LAT + k, REP_A);
        tick(8);
        check("press_level_a", {31'b0, o_btn_a}, 32'd1);
        check("press_b_untouched", {31'b0, o_btn_b}, 32'd0);
        tick(24);
        t1 = cyc;  // t0 + 32: hold count 26, repeat at 28 still due
        btn_a = 1'b1;
        tick(2);
        btn_a = 1'b0;
        tick(2);
        btn_a = 1'b1;
        push(t1 + 10, REL_A);
        tick(12);
        check("release_level_a", {31'b0, o_btn_a}, 32'd0);

        // Glitch: 3 clocks low is shorter than the debounce window
        t2 = cyc;
        btn_a = 1'b0;
        tick(3);
        btn_a = 1'b1;
        tick(10);
        check("glitch_level_a", {31'b0, o_btn_a}, 32'd0);
        check("glitch_state_a", {30'b0, st_a}, {30'b0, ST_IDLE});

        // Simultaneous press and release of both buttons
        t3 = cyc;
        btn_a = 1'b0;
        btn_b = 1'b0;
        push(t3 + LAT, PRS_A | PRS_B);
        tick(8);
        check("sim_level_a", {31'b0, o_btn_a}, 32'd1);
        check("sim_level_b", {31'b0, o_btn_b}, 32'd1);
        btn_a = 1'b1;
        btn_b = 1'b1;
        push(t3 + 8 + LAT, REL_A | REL_B);
        tick(10);

        // Reset while A is held
        t4 = cyc;
        btn_a = 1'b0;
        push(t4 + LAT, PRS_A);
        tick(10);
        res_n = 1'b0;
        #2;
        check("midreset_outputs", {24'b0, o_btn_a, o_btn_b, o_press_a, o_press_b,
                                   o_release_a, o_release_b, o_repeat_a, o_repeat_b}, 32'd0);
        check("midreset_state_a", {30'b0, st_a}, {30'b0, ST_IDLE});
        tick(2);
        res_n = 1'b1;
        t5 = cyc;
        push(t5 + LAT, PRS_A);
        tick(8);
        check("after_reset_level_a", {31'b0, o_btn_a}, 32'd1);
        btn_a = 1'b1;
        t6 = cyc;
        push(t6 + LAT, REL_A);
        tick(10);

        // Drain and report anything never seen
        wait_cyc = 0;
        while (exp_q.size() != 0 && wait_cyc < 50) begin
            tick(1);
            wait_cyc++;
        end
        while (exp_q.size() != 0) begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            total_cnt++;
            $display("FAIL missing_pulse: got nothing, expected vec %b at cycle %0d", e[5:0], e[37:6]);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 90000, meaning the number of consecutive stable samples needed to accept a level change (10 ms at 9 MHz).
REQ-002 The block SHALL have parameter LONG_PRESS_CYCLES, default 4500000, meaning the held time from acceptance to the first repeat pulse (500 ms).
REQ-003 The block SHALL have parameter REPEAT_CYCLES, default 900000, meaning the period between subsequent repeat pulses (100 ms).
REQ-004 The block SHALL have parameter ACTIVE_LOW, default 1, meaning raw button pins read 0 when pressed.
REQ-005 The block SHALL have port i_clk, input, 1 bit: the single clock (pixel clock domain), rising edge.
REQ-006 The block SHALL have port i_res_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have ports i_btn_a and i_btn_b, input, 1 bit each: raw asynchronous button pins.
REQ-008 The block SHALL have ports o_btn_a and o_btn_b, output, 1 bit each: debounced level, 1 = pressed.
REQ-009 The block SHALL have ports o_press_a and o_press_b, output, 1 bit each: one-cycle pulse on accepted press.
REQ-010 The block SHALL have ports o_release_a and o_release_b, output, 1 bit each: one-cycle pulse on accepted release.
REQ-011 The block SHALL have ports o_repeat_a and o_repeat_b, output, 1 bit each: one-cycle auto-repeat pulse while held.

Function
REQ-012 Each raw input SHALL pass through a 2-flop synchronizer and then be normalised by ACTIVE_LOW to active-high.
REQ-013 Each channel SHALL run an independent FSM with states IDLE, PRESS_WAIT, HELD and RELEASE_WAIT.
REQ-014 IDLE: a synchronized active sample SHALL move the FSM to PRESS_WAIT and clear the debounce counter.
REQ-015 PRESS_WAIT: an inactive sample SHALL return the FSM to IDLE with no output pulse (glitch rejection).
REQ-016 PRESS_WAIT: after DEBOUNCE_CYCLES consecutive active samples, the FSM SHALL enter HELD, set o_btn high, pulse o_press for exactly 1 cycle and clear the hold counter.
REQ-017 Latency from a stable raw press to o_press SHALL be exactly DEBOUNCE_CYCLES+2 clocks.
REQ-018 HELD: the hold counter SHALL increment each cycle.
REQ-019 HELD: the first o_repeat pulse SHALL occur when the hold counter reaches LONG_PRESS_CYCLES, and subsequent pulses every REPEAT_CYCLES thereafter, indefinitely and without overflow (the counter reloads, it does not wrap).
REQ-020 HELD: an inactive sample SHALL move the FSM to RELEASE_WAIT, clear the debounce counter and freeze the hold counter.
REQ-021 RELEASE_WAIT: an active sample SHALL return the FSM to HELD with the hold counter resumed and no press pulse.
REQ-022 RELEASE_WAIT: after DEBOUNCE_CYCLES consecutive inactive samples, the FSM SHALL enter IDLE, clear o_btn and pulse o_release for 1 cycle.
REQ-023 No o_repeat pulse SHALL be issued in any state other than HELD.
REQ-024 o_press, o_release and o_repeat of one channel SHALL be mutually exclusive in any cycle.
REQ-025 Channels A and B SHALL be fully independent; simultaneous events on both SHALL both be reported in the same cycle.
REQ-026 Counter widths SHALL be $clog2 of the largest count they hold plus 1.
REQ-027 Elaboration SHALL fail if any *_CYCLES parameter is less than 1.

Reset
REQ-028 While i_res_n is low, every FSM SHALL be in IDLE, all counters 0, synchronizer flops set to the inactive pin level, and all outputs 0.
REQ-029 Reset asserted mid-press SHALL abort the press without emitting o_release.
REQ-030 After reset release, a button already held SHALL produce o_press after DEBOUNCE_CYCLES+2 clocks.

Structure
REQ-031 A shared package button_pkg SHALL hold the FSM state encoding and the default timing constants.
REQ-032 The per-button logic SHALL be a sub-module button_channel, instantiated twice, with ACTIVE_LOW applied inside it.

Verification (bench parameters: DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10, REPEAT_CYCLES=3, ACTIVE_LOW=1)
REQ-033 Clean press: i_btn_a driven to 0 and held -> o_press_a is a single pulse 6 clocks later and o_btn_a=1; i_btn_b is unaffected.
REQ-034 Glitch rejection: i_btn_a at 0 for 3 clocks then back to 1 -> no pulse on any output and o_btn_a stays 0.
REQ-035 Auto-repeat: A held for 30 clocks after o_press -> o_repeat_a pulses at hold counts 10, 13, 16, 19, 22, 25, 28.
REQ-036 Bouncy release: release A, bounce low for 2 clocks, then stay high -> no o_press, exactly one o_release_a 4 stable samples after the final rise, and o_btn_a=0.
REQ-037 Simultaneous press: A and B pressed on the same edge -> o_press_a and o_press_b pulse in the same cycle.
REQ-038 Reset mid-hold: i_res_n pulsed low while A is in HELD -> all outputs 0 immediately, no o_release_a, and o_press_a reappears 6 clocks after reset release.
